// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, the FIFO entry layout
// and the sequencer state encoding.
package alu_pkg;

  // ALU opcodes
  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SHR = 3'b101;
  localparam logic [2:0] SHL = 3'b110;
  localparam logic [2:0] CMP = 3'b111;

  // One queued instruction: {load, op, data}
  localparam int ENTRY_W = 8;

  typedef struct packed {
    logic       load;
    logic [2:0] op;
    logic [3:0] data;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction input stream and result output stream of the ALU sequencer.
// master = producer/consumer side, slave = the sequencer.
interface alu_op_sequencer_if;
  logic       inValid;
  logic       inReady;
  logic       inLoad;
  logic [2:0] inOp;
  logic [3:0] inData;
  logic       outValid;
  logic       outReady;
  logic [3:0] outData;
  logic       outZero;

  modport master (
    output inValid, inLoad, inOp, inData, outReady,
    input  inReady, outValid, outData, outZero
  );

  modport slave (
    input  inValid, inLoad, inOp, inData, outReady,
    output inReady, outValid, outData, outZero
  );
endinterface

// File: rtl/alu4.sv
// Combinational 4-bit ALU driven by the sequencer. All results wrap mod 16;
// shifts move operand A by the amount in operand B; CMP yields 1 when A > B.
module alu4
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] sel,
  output logic [3:0] y
);

  // Opcode decode
  always_comb begin
    y = '0;
    case (sel)
      ADD:     y = a + b;
      SUB:     y = a - b;
      AND:     y = a & b;
      OR:      y = a | b;
      XOR:     y = a ^ b;
      SHR:     y = a >> b;
      SHL:     y = a << b;
      CMP:     y = (a > b) ? 4'd1 : 4'd0;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding queued instructions. Head entry is visible
// combinationally so the sequencer can latch it on the same edge it pops.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is dropped; there is no write-through path.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage array; contents need no reset because reads are gated by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Feeds the external ALU from a queued instruction stream. The accumulator is
// ALU operand A; each popped instruction supplies operand B and the opcode.
// Every instruction (load or op) produces one result beat on the output stream.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus,
  output logic [3:0]        aluA,
  output logic [3:0]        aluB,
  output logic [2:0]        aluSel,
  input  logic [3:0]        aluOut
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e             state_reg, state_next;
  logic [3:0]         acc_reg, acc_next;
  logic [3:0]         data_reg, data_next;
  logic [2:0]         op_reg, op_next;
  logic               load_reg, load_next;
  logic               out_valid_reg, out_valid_next;
  logic [3:0]         out_data_reg, out_data_next;
  logic               out_zero_reg, out_zero_next;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [ENTRY_W-1:0] fifo_wr_data;
  logic [ENTRY_W-1:0] fifo_rd_data;
  instr_t             head;
  logic [3:0]         result;

  // Nothing is accepted while reset is held, so queued state starts clean.
  assign bus.inReady  = !rst && (fifo_count != CW'(DEPTH));
  assign fifo_push    = bus.inValid && !fifo_full && !rst;
  assign fifo_wr_data = {bus.inLoad, bus.inOp, bus.inData};
  assign head         = instr_t'(fifo_rd_data);

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ALU ports come straight from registers so they are stable all of EXEC
  assign aluA   = acc_reg;
  assign aluB   = data_reg;
  assign aluSel = op_reg;
  assign result = load_reg ? data_reg : aluOut;

  assign bus.outValid = out_valid_reg;
  assign bus.outData  = out_data_reg;
  assign bus.outZero  = out_zero_reg;

  // State, accumulator, latched instruction and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      data_reg      <= '0;
      op_reg        <= '0;
      load_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_zero_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      data_reg      <= data_next;
      op_reg        <= op_next;
      load_reg      <= load_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_zero_reg  <= out_zero_next;
    end
  end

  // Next-state logic: pop in IDLE or on a result handshake, capture in EXEC
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    data_next      = data_reg;
    op_next        = op_reg;
    load_next      = load_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_zero_next  = out_zero_reg;
    fifo_pop       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) fifo_pop = 1'b1;
      end
      ST_EXEC: begin
        acc_next       = result;
        out_data_next  = result;
        out_zero_next  = (result == 4'd0);
        out_valid_next = 1'b1;
        state_next     = ST_DONE;
      end
      ST_DONE: begin
        if (bus.outReady) begin
          out_valid_next = 1'b0;
          if (!fifo_empty) fifo_pop = 1'b1;
          else             state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Any pop latches the head entry and starts execution next cycle
    if (fifo_pop) begin
      op_next    = head.op;
      data_next  = head.data;
      load_next  = head.load;
      state_next = ST_EXEC;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with the 4-bit ALU beside it.
// Expected results are queued when an instruction is accepted and compared
// when the matching result handshake happens.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] alu_a, alu_b, alu_res, alu_out;
  logic [2:0] alu_sel;
  logic [3:0] noise = 4'd0;

  int tests   = 0;
  int failed  = 0;
  int results = 0;
  logic [3:0] sb_q[$];
  logic [3:0] model_acc = 4'd0;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(.DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .aluA   (alu_a),
    .aluB   (alu_b),
    .aluSel (alu_sel),
    .aluOut (alu_out)
  );

  alu4 u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .sel (alu_sel),
    .y   (alu_res)
  );

  // noise lets the bench disturb aluOut while a result is being held
  assign alu_out = alu_res ^ noise;

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [2:0] op;
    logic [3:0] d;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [3:0] model(input logic [3:0] a, input logic ld,
                                       input logic [2:0] op, input logic [3:0] b);
    logic [3:0] r;
    if (ld) return b;
    case (op)
      ADD:     r = a + b;
      SUB:     r = a - b;
      AND:     r = a & b;
      OR:      r = a | b;
      XOR:     r = a ^ b;
      SHR:     r = a >> b;
      SHL:     r = a << b;
      default: r = (a > b) ? 4'd1 : 4'd0;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Offer one instruction; called at posedge+1, returns at posedge+1 after acceptance
  task automatic push_instr(input logic ld, input logic [2:0] op,
                            input logic [3:0] d, input logic [3:0] exp);
    int  waited = 0;
    bit  ok = 1'b0;
    bus.inValid = 1'b1;
    bus.inLoad  = ld;
    bus.inOp    = op;
    bus.inData  = d;
    while (!ok && waited < 300) begin
      @(negedge clk);
      if (bus.inReady) ok = 1'b1;
      else             waited++;
    end
    if (!ok) begin
      tests++; failed++;
      $display("FAIL accept_timeout: inReady %0b for 300 cycles, required 1", bus.inReady);
    end
    @(posedge clk); #1;
    if (ok) sb_q.push_back(exp);
    $display("[TB] push load=%0b op=%0d data=%0h expect=%0h accepted=%0b", ld, op, d, exp, ok);
    bus.inValid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      tests++; failed++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Result monitor: handshake is decided by values stable at the negedge
  initial begin
    logic [3:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && bus.outValid && bus.outReady) begin
        if (sb_q.size() == 0) begin
          tests++; failed++;
          $display("FAIL unexpected_result: got %0h, required no result", bus.outData);
        end else begin
          exp = sb_q.pop_front();
          $display("[TB] result data=%0h zero=%0b expect=%0h", bus.outData, bus.outZero, exp);
          check("out_data", bus.outData, exp);
          check("out_zero", bus.outZero, (exp == 4'd0) ? 1 : 0);
          results++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e6;
    int         base;

    vecs[0]  = '{1'b1, 3'b111, 4'd5,  4'h5};
    vecs[1]  = '{1'b0, ADD,    4'd3,  4'h8};
    vecs[2]  = '{1'b1, 3'b010, 4'd2,  4'h2};
    vecs[3]  = '{1'b0, SUB,    4'd3,  4'hF};
    vecs[4]  = '{1'b0, ADD,    4'd1,  4'h0};
    vecs[5]  = '{1'b1, 3'b000, 4'd9,  4'h9};
    vecs[6]  = '{1'b0, CMP,    4'd4,  4'h1};
    vecs[7]  = '{1'b1, 3'b110, 4'd4,  4'h4};
    vecs[8]  = '{1'b0, SHL,    4'd2,  4'h0};
    vecs[9]  = '{1'b1, 3'b001, 4'd12, 4'hC};
    vecs[10] = '{1'b0, AND,    4'd3,  4'h0};
    vecs[11] = '{1'b1, 3'b101, 4'd6,  4'h6};
    vecs[12] = '{1'b0, XOR,    4'd6,  4'h0};
    vecs[13] = '{1'b1, 3'b011, 4'd10, 4'hA};
    vecs[14] = '{1'b0, OR,     4'd5,  4'hF};
    vecs[15] = '{1'b0, SHR,    4'd2,  4'h3};
    vecs[16] = '{1'b0, CMP,    4'd7,  4'h0};
    vecs[17] = '{1'b0, SUB,    4'd1,  4'hF};
    vecs[18] = '{1'b0, ADD,    4'd2,  4'h1};

    bus.inValid  = 1'b0;
    bus.inLoad   = 1'b0;
    bus.inOp     = 3'b000;
    bus.inData   = 4'd0;
    bus.outReady = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("in_ready_during_rst", bus.inReady, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.outValid, 0);
    check("rst_out_data",  bus.outData, 0);
    check("rst_out_zero",  bus.outZero, 0);
    check("rst_alu_a",     alu_a, 0);
    check("rst_alu_b",     alu_b, 0);
    check("rst_alu_sel",   alu_sel, 0);
    check("rst_in_ready",  bus.inReady, 1);

    // Table-driven vectors with a free-running consumer
    @(posedge clk); #1;
    bus.outReady = 1'b1;
    foreach (vecs[i]) push_instr(vecs[i].ld, vecs[i].op, vecs[i].d, vecs[i].exp);
    wait_drain(400);
    model_acc = vecs[18].exp;

    // Latency from acceptance into an idle block, then a held result
    bus.outReady = 1'b0;
    push_instr(1'b1, ADD, 4'd3, 4'h3);
    @(negedge clk); check("lat_after_e0", bus.outValid, 0);
    @(negedge clk); check("lat_after_e1", bus.outValid, 0);
    @(negedge clk); check("lat_after_e2", bus.outValid, 1);
    noise = 4'hA;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_valid", bus.outValid, 1);
      check("hold_data",  bus.outData, 3);
      check("hold_zero",  bus.outZero, 0);
      check("hold_acc",   alu_a, 3);
    end
    noise = 4'd0;

    // Fill the queue behind the held result, then reset during EXEC
    @(posedge clk); #1;
    model_acc = 4'h3;
    push_instr(1'b0, ADD, 4'd1, 4'h4);
    push_instr(1'b0, SUB, 4'd2, 4'h2);
    push_instr(1'b0, XOR, 4'd7, 4'h5);
    push_instr(1'b0, OR,  4'd8, 4'hD);
    @(negedge clk); check("queue_full_in_ready", bus.inReady, 0);
    @(posedge clk); #1;
    bus.outReady = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.outReady = 1'b0;
    sb_q.delete();
    model_acc = 4'd0;
    @(negedge clk); check("mid_rst_in_ready", bus.inReady, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.outReady = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", bus.outValid, 0);
    check("post_rst_out_data",  bus.outData, 0);
    check("post_rst_acc",       alu_a, 0);
    check("post_rst_in_ready",  bus.inReady, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_quiet", bus.outValid, 0);
    end
    @(posedge clk); #1;
    push_instr(1'b1, SUB, 4'd7, 4'h7);
    wait_drain(100);
    model_acc = 4'h7;

    // Fill under backpressure: one in DONE plus DEPTH queued, next one held
    bus.outReady = 1'b0;
    base = results;
    for (int i = 0; i < 5; i++) begin
      logic       ld;
      logic [2:0] op;
      logic [3:0] d;
      logic [3:0] e;
      ld = (i == 0);
      op = 3'($urandom_range(0, 7));
      d  = 4'($urandom_range(0, 15));
      e  = model(model_acc, ld, op, d);
      model_acc = e;
      push_instr(ld, op, d, e);
    end
    @(negedge clk); check("full_in_ready", bus.inReady, 0);
    @(posedge clk); #1;
    e6 = model(model_acc, 1'b0, ADD, 4'd9);
    model_acc = e6;
    fork
      push_instr(1'b0, ADD, 4'd9, e6);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("extra_held", bus.inReady, 0);
        end
        @(posedge clk); #1;
        bus.outReady = 1'b1;
      end
    join
    wait_drain(200);
    check("fill_result_count", results - base, 6);

    // Random burst with a randomly stalling consumer
    base = results;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          logic       ld;
          logic [2:0] op;
          logic [3:0] d;
          logic [3:0] e;
          ld = ($urandom_range(0, 3) == 0);
          op = 3'($urandom_range(0, 7));
          d  = 4'($urandom_range(0, 15));
          e  = model(model_acc, ld, op, d);
          model_acc = e;
          push_instr(ld, op, d, e);
        end
      end
      begin
        for (int i = 0; i < 150; i++) begin
          @(posedge clk); #1;
          bus.outReady = ($urandom_range(0, 1) == 1);
        end
        bus.outReady = 1'b1;
      end
    join
    wait_drain(400);
    check("burst_result_count", results - base, 24);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
